load_store_unit: RTL and testbench

Multi-cycle data-memory access unit that sits directly downstream of the execute stage, in place of the single-cycle data memory. It accepts one load or store per handshake, checks alignment, and drives a word-wide ack-based data bus with byte-lane strobes. It returns the sign- or zero-extended load value (valM) or a fault, and times out stalled bus accesses.

---
 rtl/load_store_unit_pkg.sv | 23 ++
 rtl/load_store_unit_load_align.sv | 35 +++
 rtl/load_store_unit.sv | 175 +++++++++++++++++
 tb/tb_load_store_unit.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/load_store_unit_pkg.sv
// Shared opcode definitions for the memory path.
//   mem_width_t   : access size encoding used by fetch_stage and load_store_unit
//   is_misaligned : true when a request cannot be issued to the word bus
package load_store_unit_pkg;

  typedef enum logic [1:0] {
    MEM_BYTE = 2'b00,
    MEM_HALF = 2'b01,
    MEM_WORD = 2'b10
  } mem_width_t;

  // Width 2'b11 is not a legal size and is reported like a misalignment.
  function automatic logic is_misaligned(input logic [1:0] width,
                                         input logic [1:0] off);
    case (width)
      MEM_BYTE: is_misaligned = 1'b0;
      MEM_HALF: is_misaligned = off[0];
      MEM_WORD: is_misaligned = |off;
      default:  is_misaligned = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_load_align.sv
// load_align: picks the addressed byte/half/word out of a bus read word and
// sign- or zero-extends it to 32 bits. Purely combinational.
//   width       : access size (mem_width_t)
//   off         : byte offset within the word (address bits [1:0])
//   sign_extend : 1 = sign-extend sub-word values, 0 = zero-extend
//   word        : raw word returned by the bus
//   value       : formatted load result
module load_align
  import load_store_unit_pkg::*;
(
  input  mem_width_t  width,
  input  logic [1:0]  off,
  input  logic        sign_extend,
  input  logic [31:0] word,
  output logic [31:0] value
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Half accesses are known aligned, so only off[1] picks the half.
  assign byte_sel = word[{off, 3'b000} +: 8];
  assign half_sel = word[{off[1], 4'b0000} +: 16];

  // NOTE: every output of an always_comb gets a value on every path (here via
  // the default arm); a missed path silently infers a latch.
  always_comb begin
    case (width)
      MEM_BYTE: value = {{24{sign_extend & byte_sel[7]}}, byte_sel};
      MEM_HALF: value = {{16{sign_extend & half_sel[15]}}, half_sel};
      default:  value = word;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: multi-cycle data-memory access unit behind the execute stage.
// Accepts one load/store per handshake, rejects misaligned or illegal-width
// requests without touching the bus, drives an ack-based word bus with byte
// strobes, and returns a formatted load value or a fault. Bus accesses that
// see no ack for TIMEOUT cycles are abandoned with a fault.
//   clock, reset        : rising-edge clock, asynchronous active-high reset
//   req_*               : request handshake from execute (ready only in IDLE)
//   resp_valid          : one-cycle completion pulse
//   resp_rdata/fault    : registered result, held until the next completion
//   bus_req/we/addr     : bus access control, stable for the whole access
//   bus_wstrb/wdata     : lane strobes and lane-replicated store data
//   bus_ack/rdata       : bus completion and read data
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 16
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_write,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  input  logic [1:0]      req_width,
  input  logic            req_sign_extend,
  output logic            resp_valid,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_fault,
  output logic            bus_req,
  output logic            bus_we,
  output logic [XLEN-1:0] bus_addr,
  output logic [3:0]      bus_wstrb,
  output logic [XLEN-1:0] bus_wdata,
  input  logic            bus_ack,
  input  logic [XLEN-1:0] bus_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUS  = 2'b01,
    RESP = 2'b10
  } state_t;

  localparam int CW = $clog2(TIMEOUT + 1);

  state_t          state, next_state;
  logic [CW-1:0]   count;
  logic            lat_write;
  logic [XLEN-1:0] lat_addr;
  logic [XLEN-1:0] lat_wdata;
  mem_width_t      lat_width;
  logic            lat_sign;

  logic            accept;
  logic            reject;
  logic            timeout_hit;
  logic [XLEN-1:0] load_value;
  logic [1:0]      off;

  assign off = lat_addr[1:0];

  // ---------------------------------------------------------------- FSM ----
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state  = state;
    req_ready   = 1'b0;
    bus_req     = 1'b0;
    resp_valid  = 1'b0;
    accept      = 1'b0;
    reject      = 1'b0;
    timeout_hit = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          accept = 1'b1;
          if (is_misaligned(req_width, req_addr[1:0])) begin
            reject     = 1'b1;
            next_state = RESP;
          end else begin
            next_state = BUS;
          end
        end
      end
      BUS: begin
        bus_req = 1'b1;
        // An ack in the final allowed cycle still completes the access.
        if (bus_ack) begin
          next_state = RESP;
        end else if (count == CW'(TIMEOUT - 1)) begin
          timeout_hit = 1'b1;
          next_state  = RESP;
        end
      end
      RESP: begin
        resp_valid = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // ------------------------------------------------------------ datapath ---
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count      <= '0;
      lat_write  <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      lat_width  <= MEM_BYTE;
      lat_sign   <= 1'b0;
      resp_rdata <= '0;
      resp_fault <= 1'b0;
    end else begin
      if (accept) begin
        count     <= '0;
        lat_write <= req_write;
        lat_addr  <= req_addr;
        lat_wdata <= req_wdata;
        lat_width <= mem_width_t'(req_width);
        lat_sign  <= req_sign_extend;
      end
      if (state == BUS && !bus_ack) count <= count + 1'b1;

      if (reject || timeout_hit) begin
        resp_rdata <= '0;
        resp_fault <= 1'b1;
      end else if (state == BUS && bus_ack) begin
        resp_rdata <= lat_write ? '0 : load_value;
        resp_fault <= 1'b0;
      end
    end
  end

  load_align u_load_align (
    .width       (lat_width),
    .off         (off),
    .sign_extend (lat_sign),
    .word        (bus_rdata),
    .value       (load_value)
  );

  // ------------------------------------------------------------ bus side ---
  assign bus_we   = lat_write;
  assign bus_addr = {lat_addr[XLEN-1:2], 2'b00};

  always_comb begin
    bus_wdata = lat_wdata;
    bus_wstrb = 4'b1111;
    case (lat_width)
      MEM_BYTE: begin
        bus_wdata = {4{lat_wdata[7:0]}};
        bus_wstrb = 4'b0001 << off;
      end
      MEM_HALF: begin
        bus_wdata = {2{lat_wdata[15:0]}};
        bus_wstrb = 4'b0011 << off;
      end
      default: begin
        bus_wdata = lat_wdata;
        bus_wstrb = 4'b1111;
      end
    endcase
    if (!lat_write) bus_wstrb = 4'b0000;
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed cases followed by random
// requests, each checked cycle by cycle against a size/offset arithmetic model.
module tb_load_store_unit;

  localparam int TIMEOUT_CYC = 16;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [1:0]  req_width;
  logic        req_sign_extend;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_fault;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  load_store_unit #(.XLEN(32), .TIMEOUT(TIMEOUT_CYC)) dut (
    .clock           (clock),
    .reset           (reset),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_write       (req_write),
    .req_addr        (req_addr),
    .req_wdata       (req_wdata),
    .req_width       (req_width),
    .req_sign_extend (req_sign_extend),
    .resp_valid      (resp_valid),
    .resp_rdata      (resp_rdata),
    .resp_fault      (resp_fault),
    .bus_req         (bus_req),
    .bus_we          (bus_we),
    .bus_addr        (bus_addr),
    .bus_wstrb       (bus_wstrb),
    .bus_wdata       (bus_wdata),
    .bus_ack         (bus_ack),
    .bus_rdata       (bus_rdata)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: an access of n bytes is legal only if the address is a
  // multiple of n; loads take n bytes starting at byte offset off.
  function automatic void model(input bit wr, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [1:0] width,
                                input bit se, input logic [31:0] rword,
                                input int ack_delay,
                                output bit fault, output logic [31:0] rdata,
                                output logic [31:0] bwdata, output logic [3:0] strb,
                                output int nbus);
    int n;
    int off;
    bit bad;
    longint unsigned v;
    longint unsigned modv;
    logic [7:0]  b;
    logic [15:0] h;
    n   = 1 << width;
    off = int'(addr % 4);
    bad = (width == 2'd3) || ((addr % n) != 0);
    nbus  = bad ? 0 : ((ack_delay < TIMEOUT_CYC) ? ack_delay + 1 : TIMEOUT_CYC);
    fault = bad || (ack_delay >= TIMEOUT_CYC);
    rdata = '0; bwdata = '0; strb = '0;
    if (!bad) begin
      modv = 64'd1 << (8 * n);
      v = rword;
      v = (v >> (8 * off)) % modv;
      if (se && n < 4 && v >= modv / 2) v = v + (64'h1_0000_0000 - modv);
      if (!fault && !wr) rdata = v[31:0];
      strb = 4'(((1 << n) - 1) << off);
      b = wdata[7:0];
      h = wdata[15:0];
      if (n == 1)      bwdata = 32'(b) * 32'h0101_0101;
      else if (n == 2) bwdata = 32'(h) * 32'h0001_0001;
      else             bwdata = wdata;
    end
  endfunction

  // Entered and left at a falling edge; the request is accepted at the
  // following rising edge, so back-to-back calls exercise accept-after-resp.
  task automatic do_op(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [1:0] width, input bit se, input logic [31:0] rword,
                       input int ack_delay);
    bit          e_fault;
    logic [31:0] e_rdata, e_wdata;
    logic [3:0]  e_strb;
    int          nbus;
    model(wr, addr, wdata, width, se, rword, ack_delay, e_fault, e_rdata, e_wdata, e_strb, nbus);
    check("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wdata;
    req_width = width; req_sign_extend = se;
    @(posedge clock); #1;
    req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom;
    req_width = 2'($urandom); req_write = 1'($urandom); req_sign_extend = 1'($urandom);
    for (int j = 0; j < nbus; j++) begin
      @(negedge clock);
      check("bus_req", 32'(bus_req), 32'd1);
      check("resp_valid_busy", 32'(resp_valid), 32'd0);
      check("req_ready_busy", 32'(req_ready), 32'd0);
      check("bus_addr", bus_addr, {addr[31:2], 2'b00});
      check("bus_we", 32'(bus_we), 32'(wr));
      check("bus_wstrb", 32'(bus_wstrb), wr ? 32'(e_strb) : 32'd0);
      if (wr) check("bus_wdata", bus_wdata, e_wdata);
      if (j == ack_delay) begin bus_ack = 1'b1; bus_rdata = rword; end
      else                bus_rdata = $urandom;
      @(posedge clock); #1;
      bus_ack = 1'b0; bus_rdata = $urandom;
    end
    @(negedge clock);
    check("resp_valid", 32'(resp_valid), 32'd1);
    check("bus_req_resp", 32'(bus_req), 32'd0);
    check("resp_fault", 32'(resp_fault), 32'(e_fault));
    check("resp_rdata", resp_rdata, e_rdata);
    @(negedge clock);
    check("resp_valid_pulse", 32'(resp_valid), 32'd0);
    check("resp_rdata_hold", resp_rdata, e_rdata);
    check("resp_fault_hold", 32'(resp_fault), 32'(e_fault));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    req_width = '0; req_sign_extend = 1'b0; bus_ack = 1'b0; bus_rdata = '0;
    #1;
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_bus_req", 32'(bus_req), 32'd0);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    check("rst_resp_fault", 32'(resp_fault), 32'd0);
    check("rst_bus_wstrb", 32'(bus_wstrb), 32'd0);
    check("rst_bus_addr", bus_addr, 32'd0);
    check("rst_bus_we", 32'(bus_we), 32'd0);
    repeat (2) @(negedge clock);
    reset = 1'b0;

    // Directed cases.
    do_op(1'b0, 32'h100, 32'h0, 2'b10, 1'b0, 32'hDEAD_BEEF, 3);
    do_op(1'b0, 32'h103, 32'h0, 2'b00, 1'b1, 32'h80FF_0000, 0);
    check("signed_byte_const", resp_rdata, 32'hFFFF_FF80);
    do_op(1'b0, 32'h103, 32'h0, 2'b00, 1'b0, 32'h80FF_0000, 0);
    check("unsigned_byte_const", resp_rdata, 32'h0000_0080);
    do_op(1'b1, 32'h202, 32'h1234_ABCD, 2'b01, 1'b0, 32'h5555_5555, 0);
    do_op(1'b0, 32'h101, 32'h0, 2'b10, 1'b0, 32'h0, 0);
    do_op(1'b0, 32'h100, 32'h0, 2'b11, 1'b0, 32'h0, 0);
    do_op(1'b0, 32'h102, 32'h0, 2'b01, 1'b1, 32'h8001_7FFF, 1);
    do_op(1'b0, 32'h180, 32'h0, 2'b10, 1'b0, 32'h1111_2222, 1000);
    do_op(1'b0, 32'h184, 32'h0, 2'b10, 1'b0, 32'h3333_4444, TIMEOUT_CYC - 1);
    do_op(1'b1, 32'h301, 32'hA5A5_A5C3, 2'b00, 1'b0, 32'h0, 2);

    // Reset in the middle of a bus access abandons it.
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h300; req_width = 2'b10;
    req_sign_extend = 1'b0;
    @(posedge clock); #1;
    req_valid = 1'b0;
    @(negedge clock);
    check("pre_reset_bus_req", 32'(bus_req), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("mid_reset_bus_req", 32'(bus_req), 32'd0);
    check("mid_reset_req_ready", 32'(req_ready), 32'd1);
    check("mid_reset_resp_valid", 32'(resp_valid), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      check("post_reset_resp_valid", 32'(resp_valid), 32'd0);
      check("post_reset_bus_req", 32'(bus_req), 32'd0);
    end
    do_op(1'b0, 32'h304, 32'h0, 2'b10, 1'b0, 32'hCAFE_F00D, 2);

    // Random traffic.
    for (int i = 0; i < 150; i++) begin
      int r;
      int dly;
      r = $urandom_range(0, 19);
      if (r == 0)      dly = TIMEOUT_CYC + 3;
      else if (r == 1) dly = TIMEOUT_CYC - 1;
      else             dly = $urandom_range(0, 5);
      do_op(1'($urandom), $urandom, $urandom, 2'($urandom), 1'($urandom), $urandom, dly);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
